// File: rtl/mult_pkg.sv
// Shared state encoding for the sequential shift-add multiplier and its bench.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  function automatic logic state_busy(input mult_state_t s);
    return (s == ADD) || (s == SHIFT);
  endfunction

endpackage

// File: rtl/bit_counter.sv
// Loadable down counter with zero flag; clear beats load beats decrement, never wraps below zero.
module bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic          dec_i,
  input  logic [CW-1:0] val_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mult_seq_param.sv
// WIDTH-bit shift-add multiplier with start/ready handshake and synchronous abort.
// Define MULT_SIGNED_EN to add the signed_i port and two's-complement operation.
module mult_seq_param
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef MULT_SIGNED_EN
  input  logic               signed_i,
`endif
  output logic [2*WIDTH-1:0] product,
  output logic               ready,
  output logic               busy,
  output logic               add_o,
  output logic               shift_o
);

  localparam int CW = $clog2(WIDTH + 1);

  mult_state_t      state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             c_q, c_d;

  logic             cnt_clr, cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sum;
  logic             shift_msb;

  bit_counter #(.CW(CW)) u_cnt (
    .clk    (clk),
    .n_reset(n_reset),
    .clr_i  (cnt_clr),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .val_i  (CW'(WIDTH)),
    .cnt_o  (cnt),
    .zero_o (cnt_zero)
  );

`ifdef MULT_SIGNED_EN
  logic           sgn_q, sgn_d;
  logic [WIDTH:0] a_ext, m_ext;

  // The multiplier's sign bit carries negative weight, so its partial product is subtracted.
  always_comb begin
    a_ext     = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    m_ext     = sgn_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
    sum       = (sgn_q && (cnt == CW'(1))) ? (a_ext - m_ext) : (a_ext + m_ext);
    shift_msb = sgn_q & c_q;
  end
`else
  logic cnt_unused;

  assign sum        = {1'b0, a_q} + {1'b0, m_q};
  assign shift_msb  = 1'b0;
  assign cnt_unused = ^cnt;
`endif

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    a_d      = a_q;
    q_d      = q_q;
    c_d      = c_q;
`ifdef MULT_SIGNED_EN
    sgn_d    = sgn_q;
`endif
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      m_d     = '0;
      a_d     = '0;
      q_d     = '0;
      c_d     = 1'b0;
`ifdef MULT_SIGNED_EN
      sgn_d   = 1'b0;
`endif
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            m_d      = a;
            q_d      = b;
            a_d      = '0;
            c_d      = 1'b0;
`ifdef MULT_SIGNED_EN
            sgn_d    = signed_i;
`endif
            cnt_load = 1'b1;
            state_d  = ADD;
          end
        end
        ADD: begin
          cnt_dec = 1'b1;
          if (q_q[0]) begin
            {c_d, a_d} = sum;
          end
          state_d = SHIFT;
        end
        SHIFT: begin
          {c_d, a_d, q_d} = {shift_msb, c_q, a_q, q_q[WIDTH-1:1]};
          state_d = cnt_zero ? DONE : ADD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
`ifdef MULT_SIGNED_EN
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
`ifdef MULT_SIGNED_EN
      sgn_q   <= sgn_d;
`endif
    end
  end

  always_comb begin
    product = {a_q, q_q};
    ready   = (state_q == DONE);
    busy    = state_busy(state_q);
    add_o   = (state_q == ADD) && q_q[0];
    shift_o = (state_q == SHIFT);
  end

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param (WIDTH=8): products, latency, abort, reset, handshake corners.
module tb_mult_seq_param;

  logic        clk;
  logic        n_reset;
  logic        start;
  logic        abort;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        signed_i;
  logic [15:0] product;
  logic        ready;
  logic        busy;
  logic        add_o;
  logic        shift_o;

  int tests_run;
  int tests_failed;
  int lat;
  int busy_cnt;
  int add_cnt;
  int shift_cnt;

  mult_seq_param #(.WIDTH(8)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start),
    .abort   (abort),
    .a       (a),
    .b       (b),
`ifdef MULT_SIGNED_EN
    .signed_i(signed_i),
`endif
    .product (product),
    .ready   (ready),
    .busy    (busy),
    .add_o   (add_o),
    .shift_o (shift_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge; counts edges until ready and activity seen meanwhile.
  task automatic wait_done(input string tag, input int exp_lat);
    lat = 0; busy_cnt = 0; add_cnt = 0; shift_cnt = 0;
    while (ready !== 1'b1 && lat < 100) begin
      if (busy === 1'b1)    busy_cnt++;
      if (add_o === 1'b1)   add_cnt++;
      if (shift_o === 1'b1) shift_cnt++;
      tick();
      lat++;
    end
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic run_op(input string tag, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [15:0] exp, input int exp_adds);
    a = aa; b = bb; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(tag, 16);
    $display("[TB] %s a=%h b=%h product=%h lat=%0d adds=%0d", tag, aa, bb, product, lat, add_cnt);
    check({tag, "_prod"}, 32'(product), 32'(exp));
    check({tag, "_busy"}, 32'(busy_cnt), 32'd16);
    check({tag, "_adds"}, 32'(add_cnt), 32'(exp_adds));
    check({tag, "_shifts"}, 32'(shift_cnt), 32'd8);
    tick();
    check({tag, "_hold"}, 32'({ready, product}), 32'({1'b1, exp}));
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    n_reset = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; signed_i = 1'b0;
    repeat (2) tick();
    check("rst_outs", 32'({product, ready, busy, add_o, shift_o}), 32'd0);
    n_reset = 1'b1;
    tick();
    check("idle_outs", 32'({product, ready, busy, add_o, shift_o}), 32'd0);

    run_op("u_0d_0b", 8'h0D, 8'h0B, 16'h008F, 3);
    run_op("u_ff_ff", 8'hFF, 8'hFF, 16'hFE01, 8);
    run_op("u_00_a5", 8'h00, 8'hA5, 16'h0000, 4);
    run_op("u_a5_00", 8'hA5, 8'h00, 16'h0000, 0);
    run_op("u_12_34", 8'h12, 8'h34, 16'h03A8, 3);
    run_op("u_80_02", 8'h80, 8'h02, 16'h0100, 1);
    run_op("u_01_ff", 8'h01, 8'hFF, 16'h00FF, 8);
    run_op("u_ff_01", 8'hFF, 8'h01, 16'h00FF, 1);

    // Start pulsed at the fifth edge (accept = first edge) must be ignored.
    a = 8'h0D; b = 8'h0B; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    a = 8'h01; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_done("ign", 12);
    $display("[TB] ign_start product=%h lat=%0d", product, lat);
    check("ign_prod", 32'(product), 32'h008F);

    // Abort mid-operation clears everything and parks in IDLE.
    a = 8'h0D; b = 8'h0B; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    $display("[TB] abort product=%h ready=%b busy=%b", product, ready, busy);
    check("abort_outs", 32'({product, ready, busy}), 32'd0);
    tick();
    check("abort_idle", 32'(busy), 32'd0);
    run_op("post_abort", 8'h0E, 8'h0F, 16'h00D2, 4);

    // Abort and start together in DONE: abort wins.
    abort = 1'b1; start = 1'b1; a = 8'h03; b = 8'h03;
    tick();
    abort = 1'b0; start = 1'b0;
    $display("[TB] abort_vs_start product=%h busy=%b", product, busy);
    check("abort_vs_start", 32'({product, ready, busy}), 32'd0);

    // Asynchronous reset while in SHIFT.
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_shift", 32'(shift_o), 32'd1);
    #1 n_reset = 1'b0;
    #1;
    $display("[TB] async_reset product=%h busy=%b shift=%b", product, busy, shift_o);
    check("async_rst", 32'({product, ready, busy, add_o, shift_o}), 32'd0);
    tick();
    n_reset = 1'b1;
    tick();
    check("post_rst_idle", 32'({product, busy}), 32'd0);

    // Start held high: DONE reloads straight into ADD.
    a = 8'h0D; b = 8'h0B; start = 1'b1;
    tick();
    wait_done("b2b_first", 16);
    check("b2b_first_prod", 32'(product), 32'h008F);
    a = 8'h02; b = 8'h03;
    tick();
    start = 1'b0;
    check("b2b_no_idle", 32'({busy, ready}), 32'b10);
    wait_done("b2b_second", 16);
    $display("[TB] back_to_back product=%h lat=%0d", product, lat);
    check("b2b_second_prod", 32'(product), 32'h0006);

`ifdef MULT_SIGNED_EN
    signed_i = 1'b1;
    run_op("s_fd_05", 8'hFD, 8'h05, 16'hFFF1, 2);
    run_op("s_80_80", 8'h80, 8'h80, 16'h4000, 1);
    run_op("s_05_fd", 8'h05, 8'hFD, 16'hFFF1, 7);
    signed_i = 1'b0;
    run_op("s_off_fd_05", 8'hFD, 8'h05, 16'h04F1, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
